// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 / 8E1 serialiser, LSB first.
// Queued bytes go out back-to-back; the line is registered and idles high.
module uart_tx #(
  parameter int CLK_FREQ   = 108_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int IF_PARITY  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       overflow_o,
  output logic       busy_o,
  output logic       uart_tx_o
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          overflow_q;
  logic          full, empty, push, pop;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          baud_last;

  // full is taken from the pre-pop count, so a write while full is always dropped
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = wr_i & ~full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q      <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow_q <= wr_i & full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    byte_q  <= byte_d;
  end

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = baud_last ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          byte_d  = mem_q[rptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            if (IF_PARITY != 0) begin
              tx_d    = ^byte_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (!empty) begin
            // chain straight into the next start bit with no idle gap
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            byte_d  = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign full_o     = full;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != S_IDLE) | ~empty;
  assign uart_tx_o  = tx_q;

endmodule
